// File: rtl/j_arith_pkg.sv
// Shared arithmetic definitions for the serial adder/subtractor family.
package j_arith_pkg;

   // Operand width shared with the ripple-carry adder so the two can be cross-checked.
   localparam int J_DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bits needed to count 0..value-1; never narrower than one bit so WIDTH=1 still has a counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/j_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module j_full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference and borrow of one bit position.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/j_serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for start; operands captured when start is seen
//  ST_SHIFT | one full-subtractor step per cycle, WIDTH cycles, busy=1
//  ST_DONE  | one cycle, done=1, diff/borrowout freshly loaded
module j_serial_subtractor
   import j_arith_pkg::*;
#(
   parameter int WIDTH = J_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrowin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrowout
);

   localparam int            CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             br;
   logic             d_bit;
   logic             br_next;

   j_full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_next)
   );

   // New difference bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
   always_comb begin
      res_next = (res_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
   end

   // Sequencer and datapath; diff/borrowout only move on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         br        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         diff      <= '0;
         borrowout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  br     <= borrowin;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  diff      <= res_next;
                  borrowout <= br_next;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_j_serial_subtractor.sv
// Directed and cross-check bench for the serial subtractor (WIDTH=4).
module tb_j_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       borrowin;
   logic       busy;
   logic       done;
   logic [3:0] diff;
   logic       borrowout;

   logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

   int n_cmp = 0;
   int n_err = 0;

   j_serial_subtractor #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .borrowin  (borrowin),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrowout (borrowout)
   );

   j_full_subtractor u_fs (
      .a    (fs_a),
      .b    (fs_b),
      .bin  (fs_bin),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always #5 clk = ~clk;

   // Starts one operation and watches it; lat = cycles from start edge to done (-1 if none).
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                         output int lat, output int bcnt);
      @(negedge clk);
      a = av; b = bv; borrowin = cv; start = 1'b1;
      @(posedge clk);
      lat = -1;
      bcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_full_subtractor();
      int dv, exp_d, exp_b;
      for (int i = 0; i < 8; i++) begin
         fs_a = i[2]; fs_b = i[1]; fs_bin = i[0];
         #1;
         dv = int'(fs_a) - int'(fs_b) - int'(fs_bin);
         exp_d = dv & 1;
         exp_b = (dv < 0) ? 1 : 0;
         n_cmp++;
         if ({fs_d, fs_bout} !== {exp_d[0], exp_b[0]}) begin
            n_err++;
            $display("FAIL fs_cell a=%0b b=%0b bin=%0b: got d=%0b bout=%0b, want d=%0d bout=%0d",
                     fs_a, fs_b, fs_bin, fs_d, fs_bout, exp_d, exp_b);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0; borrowin = 1'b0;
      #12;
      n_cmp++;
      if ({busy, done, diff, borrowout} !== 7'd0) begin
         n_err++;
         $display("FAIL reset_asserted: got busy=%0b done=%0b diff=%0d bo=%0b, want all 0",
                  busy, done, diff, borrowout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done, diff, borrowout} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_idle cyc%0d: got busy=%0b done=%0b diff=%0d bo=%0b, want all 0",
                     k, busy, done, diff, borrowout);
         end
      end
   endtask

   task automatic test_vectors();
      logic [3:0] va [4] = '{4'd0, 4'd3, 4'd7,  4'd15};
      logic [3:0] vb [4] = '{4'd0, 4'd2, 4'd10, 4'd15};
      logic       vc [4] = '{1'b0, 1'b1, 1'b0,  1'b1};
      logic [3:0] ed [4] = '{4'd0, 4'd0, 4'd13, 4'd15};
      logic       eb [4] = '{1'b0, 1'b0, 1'b1,  1'b1};
      int lat, bcnt;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vc[i], lat, bcnt);
         n_cmp++;
         if (lat !== 4) begin
            n_err++;
            $display("FAIL vec%0d_latency: got %0d, want 4", i, lat);
         end
         n_cmp++;
         if (bcnt !== 4) begin
            n_err++;
            $display("FAIL vec%0d_busy_cycles: got %0d, want 4", i, bcnt);
         end
         n_cmp++;
         if (diff !== ed[i]) begin
            n_err++;
            $display("FAIL vec%0d_diff: got %0d, want %0d", i, diff, ed[i]);
         end
         n_cmp++;
         if (borrowout !== eb[i]) begin
            n_err++;
            $display("FAIL vec%0d_borrowout: got %0b, want %0b", i, borrowout, eb[i]);
         end
         @(negedge clk);
         n_cmp++;
         if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL vec%0d_after_done: got busy=%0b done=%0b, want 0 0", i, busy, done);
         end
      end
   endtask

   // Previous result is 15/1 from the last vector; it must hold until the new done.
   task automatic test_operand_hold();
      int lat;
      logic stable;
      @(negedge clk);
      a = 4'd5; b = 4'd1; borrowin = 1'b0; start = 1'b1;
      @(posedge clk);
      lat = -1;
      stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = 1'b0; a = 4'd0; b = 4'd0;
         if (done) begin
            lat = k;
            break;
         end
         if (diff !== 4'd15 || borrowout !== 1'b1) stable = 1'b0;
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_err++;
         $display("FAIL hold_prev_result: got unstable diff/borrowout before done, want 15/1 held");
      end
      n_cmp++;
      if (lat !== 4) begin
         n_err++;
         $display("FAIL hold_latency: got %0d, want 4", lat);
      end
      n_cmp++;
      if ({diff, borrowout} !== {4'd4, 1'b0}) begin
         n_err++;
         $display("FAIL hold_result: got diff=%0d bo=%0b, want diff=4 bo=0", diff, borrowout);
      end
   endtask

   task automatic test_busy_collision();
      int ndone, first;
      @(negedge clk);
      a = 4'd9; b = 4'd4; borrowin = 1'b0; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      first = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first < 0) first = k;
         end
         case (k)
            0: start = 1'b0;
            1: begin start = 1'b1; a = 4'd1; b = 4'd2; end
            2: start = 1'b0;
            4: start = 1'b1;
            5: start = 1'b0;
            default: ;
         endcase
      end
      n_cmp++;
      if (ndone !== 1 || first !== 4) begin
         n_err++;
         $display("FAIL collision_done: got %0d pulses first at %0d, want 1 at 4", ndone, first);
      end
      n_cmp++;
      if ({diff, borrowout} !== {4'd5, 1'b0}) begin
         n_err++;
         $display("FAIL collision_result: got diff=%0d bo=%0b, want diff=5 bo=0", diff, borrowout);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL collision_idle: got busy=%0b, want 0", busy);
      end
   endtask

   task automatic test_reset_midop();
      int ndone, lat, bcnt;
      @(negedge clk);
      a = 4'd8; b = 4'd1; borrowin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, diff, borrowout} !== 7'd0) begin
         n_err++;
         $display("FAIL midop_reset: got busy=%0b done=%0b diff=%0d bo=%0b, want all 0",
                  busy, done, diff, borrowout);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      n_cmp++;
      if (ndone !== 0) begin
         n_err++;
         $display("FAIL midop_no_done: got %0d active cycles, want 0", ndone);
      end
      run_op(4'd0, 4'd0, 1'b1, lat, bcnt);
      n_cmp++;
      if (lat !== 4 || {diff, borrowout} !== {4'd15, 1'b1}) begin
         n_err++;
         $display("FAIL midop_after: got lat=%0d diff=%0d bo=%0b, want lat=4 diff=15 bo=1",
                  lat, diff, borrowout);
      end
   endtask

   // Adder reference A+B+cin, then subtract B and cin back out.
   task automatic test_cross_check();
      int av, bv, cv, sv, lat, bcnt;
      logic exp_bo;
      for (int i = 0; i < 200; i++) begin
         av = int'($urandom_range(15, 0));
         bv = int'($urandom_range(15, 0));
         cv = int'($urandom_range(1, 0));
         sv = (av + bv + cv) % 16;
         exp_bo = (sv < bv + cv);
         run_op(4'(sv), 4'(bv), cv[0], lat, bcnt);
         n_cmp++;
         if (lat !== 4 || diff !== 4'(av) || borrowout !== exp_bo) begin
            n_err++;
            $display("FAIL xcheck%0d s=%0d b=%0d c=%0d: got lat=%0d diff=%0d bo=%0b, want lat=4 diff=%0d bo=%0b",
                     i, sv, bv, cv, lat, diff, borrowout, av, exp_bo);
         end
      end
   endtask

   initial begin
      test_full_subtractor();
      test_reset();
      test_vectors();
      test_operand_hold();
      test_busy_collision();
      test_reset_midop();
      test_cross_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
